isquare: RTL
============

Name: isquare

Overview:
- Inverse of the integer square-root unit: takes a root and a remainder, and rebuilds the radicand as result = root*root + rem.
- Uses an iterative shift-add multiplier with a start/valid handshake, one multiplier bit per cycle.
- Sits beside the square-root unit. It re-expands {sol, rem} pairs for self-checking and as the forward (squaring) path of the numeric datapath.

Parameters:
- W, 4, root width in bits. The remainder is W+1 bits and the result is 2W bits.

Ports:
- clk  input  1  system clock, rising edge.
- clr  input  1  reset; synchronous and active-high.
- start  input  1  request. Sampled only in IDLE.
- root  input  W  root operand. Captured on the edge that accepts start.
- rem  input  W+1  remainder operand. Captured with root.
- result  output  2W  root*root + rem. Held stable until the next accepted start.
- valid  output  1  one-cycle pulse: result is new this cycle.
- busy  output  1  high while in CALC or DONE.
- rem_err  output  1  present only with ISQUARE_CHECK_EN; see Optional Feature.

Behaviour:
- Reset (clr=1 at a rising edge):
  - state=IDLE; result=0, valid=0, busy=0, rem_err=0; internal registers cleared.
  - clr has priority over every other input.
  - clr mid-operation aborts the operation; no valid is produced.
- Internal registers:
  - acc: 2W bits.
  - mcand: 2W bits.
  - mplier: W bits.
  - cnt: ceil(log2(W+1)) bits.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - On start=1: acc <= zero-extended rem; mcand <= zero-extended root; mplier <= root; cnt <= 0; go to CALC.
  - On start=0: stay in IDLE.
- CALC, once per cycle:
  - If mplier[0]=1, acc <= acc + mcand.
  - Then mcand <= mcand<<1, mplier <= mplier>>1, cnt <= cnt+1.
  - When cnt reaches W-1 on this edge, also go to DONE.
  - CALC lasts exactly W cycles. There is no early exit when mplier becomes 0, so latency is fixed.
- DONE: result <= acc, valid=1 for this cycle only; next state IDLE.
- Latency and throughput:
  - Start accepted at edge E. CALC occupies cycles E+1..E+W. valid is high in cycle E+W+1.
  - Throughput is one operation per W+2 cycles.
- start in CALC or DONE is ignored and not queued. Operands may change freely after the accept edge.
- start held high continuously gives back-to-back operations, each W+2 cycles apart.
- Arithmetic:
  - All additions are unsigned and 2W bits wide; no overflow is possible for legal inputs.
  - Legal inputs satisfy rem <= 2*root, so the maximum is (2^W-1)^2 + 2*(2^W-1) = 2^(2W)-1.
  - For illegal rem the sum wraps modulo 2^(2W). No error is signalled unless ISQUARE_CHECK_EN is defined.
- result keeps its last value through IDLE and CALC. It changes only on the edge entering DONE, or on clr.

Optional Feature:
- Macro: ISQUARE_CHECK_EN.
- Defined:
  - Port rem_err exists.
  - At the accept edge the block registers rem_err_q = (rem > 2*root), compared at W+1 bits.
  - rem_err = rem_err_q & valid, so it is asserted in the DONE cycle alongside valid.
  - result is still computed, with wraparound.
- Undefined: no rem_err port, no comparator logic, behaviour otherwise identical.

Decomposition:
- Package isquare_pkg:
  - State enum type {IDLE, CALC, DONE}, 2 bits.
  - Default-width constant ISQ_W=4.
  - Derived widths: result 2*ISQ_W, remainder ISQ_W+1, counter width.
- No sub-module. The FSM and shift-add datapath live in a single module. The adder is inferred.

Test Plan:
- clr=1 for 2 cycles, then idle -> result=0, valid=0, busy=0. No valid appears without a start.
- root=15, rem=30, start pulse -> valid exactly 5 cycles after the accept edge, result=255, busy high for 5 cycles.
- root=0, rem=0 -> result=0. Then root=7, rem=5 -> result=54. Then root=1, rem=2 -> result=3. Each completes in 6 cycles including IDLE.
- Pulse start again during CALC with root=2, rem=0 -> ignored; the first op's result (e.g. 54) is unchanged. start held high for 3 ops -> valid pulses spaced 6 cycles apart.
- clr asserted in the 2nd CALC cycle of root=9, rem=0 -> no valid; result=0 next cycle; a new start with root=9, rem=0 then gives 81.
- ISQUARE_CHECK_EN: root=3, rem=7 -> result=16, rem_err=1 with valid. root=3, rem=6 -> result=15, rem_err=0.

Source files
------------

// File: rtl/isquare_pkg.sv
// rtl/isquare_pkg.sv - shared types and widths for the isquare radicand rebuilder
package isquare_pkg;

    // Default root width; the remainder is one bit wider and the result is double width.
    localparam int ISQ_W     = 4;
    localparam int ISQ_RES_W = 2 * ISQ_W;
    localparam int ISQ_REM_W = ISQ_W + 1;
    localparam int ISQ_CNT_W = $clog2(ISQ_W + 1);

    // Control states of the iterative shift-add multiplier.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } isq_state_t;

endpackage

// File: rtl/isquare.sv
// rtl/isquare.sv - rebuilds result = root*root + rem with a W-cycle shift-add multiplier (optional ISQUARE_CHECK_EN adds rem_err)
module isquare
    import isquare_pkg::*;
#(
    parameter int W = ISQ_W
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [W-1:0]     root,
    input  logic [W:0]       rem,
    output logic [2*W-1:0]   result,
    output logic             valid,
    output logic             busy
`ifdef ISQUARE_CHECK_EN
    ,
    output logic             rem_err
`endif
);

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

    isq_state_t         state;
    isq_state_t         next_state;
    logic [2*W-1:0]     acc;
    logic [2*W-1:0]     acc_next;
    logic [2*W-1:0]     mcand;
    logic [W-1:0]       mplier;
    logic [CW-1:0]      cnt;
    logic               last_step;

    // Conditional partial-product add for the current multiplier bit; the
    // remainder is preloaded into acc so no separate final add is needed.
    always_comb begin
        acc_next  = acc;
        last_step = (cnt == LAST_CNT);
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

    // Next-state and handshake outputs; CALC always runs W cycles so latency is fixed.
    always_comb begin
        next_state = state;
        valid      = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last_step) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                valid      = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register; clr aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Datapath registers: operand capture on accept, one multiplier bit per CALC cycle.
    // result is loaded from the final accumulation on the edge that enters DONE,
    // so it holds the previous value through IDLE and CALC.
    always_ff @(posedge clk) begin
        if (clr) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc    <= (2*W)'(rem);
                        mcand  <= (2*W)'(root);
                        mplier <= root;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last_step) begin
                        result <= acc_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ISQUARE_CHECK_EN
    logic rem_err_q;

    // Flag an out-of-range remainder at accept; reported only alongside valid.
    always_ff @(posedge clk) begin
        if (clr) begin
            rem_err_q <= 1'b0;
        end else if (state == IDLE && start) begin
            rem_err_q <= (rem > {root, 1'b0});
        end
    end

    assign rem_err = rem_err_q & valid;
`endif

endmodule
